// File: rtl/sd_cmd_tx.sv
// SD command-line transmitter: accepts an index/argument pair, computes CRC7 with a
// serial crc7 engine, shifts the 48-bit frame out MSB-first and then idles for NCC bit-times.

module crc7 #(
  parameter int WIDTH = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic [6:0]       crc,
  output logic             ready
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [6:0]       crc_q, crc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             fb;

  // One message bit per cycle, x^7 + x^3 + 1; ready stays high until the next load.
  always_comb begin
    sr_d   = sr_q;
    crc_d  = crc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    fb     = sr_q[WIDTH-1] ^ crc_q[6];
    if (load) begin
      sr_d   = data;
      crc_d  = '0;
      cnt_d  = CW'(WIDTH);
      busy_d = 1'b1;
    end else if (busy_q && (cnt_q != '0)) begin
      sr_d  = {sr_q[WIDTH-2:0], 1'b0};
      crc_d = {crc_q[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= '0;
      crc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      crc_q  <= crc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign crc   = crc_q;
  assign ready = busy_q && (cnt_q == '0);
endmodule

module sd_cmd_tx #(
  parameter int DIV         = 4,
  parameter int NCC         = 8,
  parameter int CRC_TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  state_dbg
);
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_CRC_WAIT = 3'd2;
  localparam logic [2:0] S_SHIFT    = 3'd3;
  localparam logic [2:0] S_GAP      = 3'd4;

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (NCC > 64) ? $clog2(NCC) : 6;
  localparam int TW = $clog2(CRC_TIMEOUT + 1);

  logic [2:0]    state_q, state_d;
  logic [5:0]    index_q, index_d;
  logic [31:0]   arg_q, arg_d;
  logic [6:0]    crc_q, crc_d;
  logic [TW-1:0] to_q, to_d;
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;

  logic          crc_load, crc_ready;
  logic [6:0]    crc_val;
  logic [47:0]   frame;
  logic [TW-1:0] to_inc;
  logic          div_wrap;
  logic          done_c, error_c;

  crc7 #(.WIDTH(40)) u_crc7 (
    .clk   (clk),
    .rst   (~reset_n),
    .load  (crc_load),
    .data  ({2'b01, index_q, arg_q}),
    .crc   (crc_val),
    .ready (crc_ready)
  );

  assign frame    = {2'b01, index_q, arg_q, crc_q, 1'b1};
  assign crc_load = (state_q == S_LOAD);
  assign to_inc   = to_q + 1'b1;
  assign div_wrap = (div_q == DW'(DIV - 1));

  // Handshake: a command transfers on a cycle with cmd_valid && cmd_ready; cmd_ready is
  // high only in IDLE, and index/arg are sampled solely on that transfer edge.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    arg_d   = arg_q;
    crc_d   = crc_q;
    to_d    = to_q;
    div_d   = div_q;
    bit_d   = bit_q;
    done_c  = 1'b0;
    error_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          index_d = cmd_index;
          arg_d   = cmd_arg;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        to_d    = '0;
        state_d = S_CRC_WAIT;
      end
      S_CRC_WAIT: begin
        to_d = to_inc;
        if (crc_ready) begin
          crc_d   = crc_val;
          div_d   = '0;
          bit_d   = '0;
          state_d = S_SHIFT;
        end else if (to_inc == TW'(CRC_TIMEOUT)) begin
          error_c = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        div_d = div_wrap ? '0 : div_q + 1'b1;
        if (div_wrap) begin
          if (bit_q == BW'(47)) begin
            bit_d   = '0;
            state_d = S_GAP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        div_d = div_wrap ? '0 : div_q + 1'b1;
        if (div_wrap) begin
          if (bit_q == BW'(NCC - 1)) begin
            done_c  = 1'b1;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      index_q <= '0;
      arg_q   <= '0;
      crc_q   <= '0;
      to_q    <= '0;
      div_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      arg_q   <= arg_d;
      crc_q   <= crc_d;
      to_q    <= to_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign cmd_oe    = (state_q == S_SHIFT);
  assign cmd_out   = cmd_oe ? frame[6'd47 - bit_q[5:0]] : 1'b1;
  // A reset asserted on the final cycle must not leak a completion or error pulse.
  assign done      = done_c & reset_n;
  assign error     = error_c & reset_n;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_sd_cmd_tx.sv
// Directed bench for sd_cmd_tx: three parameterisations, a serial frame monitor and
// an expected-frame queue filled by the driver.

module tb_sd_cmd_tx;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_arg = '0;
  int          sel = 0;

  logic [2:0] vld_w, rdy_w, out_w, oe_w, busy_w, done_w, err_w;
  logic [2:0] st_w [3];

  always #5 clk = ~clk;

  assign vld_w = {sel == 2, sel == 1, sel == 0} & {3{cmd_valid}};

  sd_cmd_tx #(.DIV(1), .NCC(8), .CRC_TIMEOUT(63)) u_div1 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(vld_w[0]), .cmd_ready(rdy_w[0]),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .cmd_out(out_w[0]), .cmd_oe(oe_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .error(err_w[0]), .state_dbg(st_w[0]));

  sd_cmd_tx #(.DIV(4), .NCC(8), .CRC_TIMEOUT(63)) u_div4 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(vld_w[1]), .cmd_ready(rdy_w[1]),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .cmd_out(out_w[1]), .cmd_oe(oe_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .error(err_w[1]), .state_dbg(st_w[1]));

  sd_cmd_tx #(.DIV(1), .NCC(8), .CRC_TIMEOUT(2)) u_tmo (
    .clk(clk), .reset_n(reset_n), .cmd_valid(vld_w[2]), .cmd_ready(rdy_w[2]),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .cmd_out(out_w[2]), .cmd_oe(oe_w[2]),
    .busy(busy_w[2]), .done(done_w[2]), .error(err_w[2]), .state_dbg(st_w[2]));

  logic m_out, m_oe, m_ready, m_busy, m_done, m_err, m_valid;
  logic [2:0] m_st;
  int cur_div;
  always_comb begin
    m_out   = out_w[sel];
    m_oe    = oe_w[sel];
    m_ready = rdy_w[sel];
    m_busy  = busy_w[sel];
    m_done  = done_w[sel];
    m_err   = err_w[sel];
    m_valid = vld_w[sel];
    m_st    = st_w[sel];
    cur_div = (sel == 1) ? 4 : 1;
  end

  int checks = 0;
  int errors = 0;
  logic [47:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int   cyc = 0;
  int   done_cnt = 0, err_cnt = 0, frames_seen = 0, oe_rises = 0;
  int   oe_cnt = 0, lat_cnt = 0, last_done_cyc = -10;
  bit   lat_run = 0, prev_oe = 0, stab_bad = 0, cur_bit = 0;
  bit   mon_abort = 0, b2b_chk = 0;
  logic [47:0] sr = '0;
  logic [47:0] exp_f;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_oe) begin
      if (!prev_oe) oe_rises++;
      if ((oe_cnt % cur_div) == 0) begin
        sr = {sr[46:0], m_out};
        cur_bit = m_out;
      end else if (m_out != cur_bit) begin
        stab_bad = 1;
      end
      oe_cnt++;
    end else begin
      if (reset_n) chk("idle_line_high", m_out, 1'b1);
      if (prev_oe) begin
        if (mon_abort) begin
          mon_abort = 0;
          lat_run = 0;
        end else begin
          frames_seen++;
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", sr, 48'h0);
          end else begin
            exp_f = exp_q.pop_front();
            chk("frame", sr, exp_f);
            chk("oe_cycles", oe_cnt, 48 * cur_div);
            chk("bit_stable", stab_bad, 1'b0);
          end
        end
        oe_cnt = 0;
        stab_bad = 0;
      end
    end
    prev_oe = m_oe;
    if (m_done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (m_err) err_cnt++;
    if (lat_run) begin
      lat_cnt++;
      if (m_done) begin
        // LOAD(1) + CRC_WAIT(41: 40 serial CRC steps, then the ready cycle) + 48*DIV + 8*DIV
        chk("latency", lat_cnt, 42 + 56 * cur_div);
        lat_run = 0;
      end
    end
    if (m_valid && m_ready) begin
      lat_cnt = 0;
      lat_run = 1;
      if (b2b_chk) begin
        chk("b2b_accept_cycle", cyc, last_done_cyc + 1);
        b2b_chk = 0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_accept();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_ready && m_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] idx, input logic [31:0] arg, input bit expect_frame,
                      input logic [47:0] frame);
    if (expect_frame) exp_q.push_back(frame);
    cmd_index = idx;
    cmd_arg   = arg;
    cmd_valid = 1'b1;
    wait_accept();
    cmd_valid = 1'b0;
    cmd_index = $urandom_range(0, 63);
    cmd_arg   = $urandom;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 2000 && done_cnt < target; i++) @(posedge clk);
    chk("done_count", done_cnt, target);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d0, e0, f0, r0;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", m_ready, 1'b1);
    chk("rst_out", m_out, 1'b1);
    chk("rst_oe", m_oe, 1'b0);
    chk("rst_busy", m_busy, 1'b0);
    chk("rst_done", m_done, 1'b0);
    chk("rst_error", m_err, 1'b0);
    chk("rst_state", m_st, 3'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // CMD0, DIV=1
    send(6'd0, 32'h0, 1, 48'h400000000095);
    chk("busy_after_accept", m_busy, 1'b1);
    chk("ready_after_accept", m_ready, 1'b0);
    wait_done(1);
    chk("ready_after_done", m_ready, 1'b1);

    // CMD8, DIV=1
    send(6'd8, 32'h000001AA, 1, 48'h48000001AA87);
    wait_done(2);

    // CMD17, DIV=4
    sel = 1;
    #1;
    send(6'd17, 32'h0, 1, 48'h510000000055);
    wait_done(3);

    // back-to-back with cmd_valid held: CMD0 then CMD8
    sel = 0;
    #1;
    exp_q.push_back(48'h400000000095);
    exp_q.push_back(48'h48000001AA87);
    cmd_index = 6'd0;
    cmd_arg   = 32'h0;
    cmd_valid = 1'b1;
    wait_accept();
    cmd_index = 6'd8;
    cmd_arg   = 32'h000001AA;
    b2b_chk   = 1;
    wait_accept();
    cmd_valid = 1'b0;
    chk("b2b_checked", b2b_chk, 1'b0);
    wait_done(5);

    // reset during bit 20 of SHIFT
    d0 = done_cnt;
    send(6'd8, 32'h000001AA, 0, 48'h0);
    begin
      bit seen = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (m_oe) begin
          seen = 1;
          break;
        end
      end
      chk("shift_started", seen, 1'b1);
    end
    repeat (20) @(posedge clk);
    #1;
    mon_abort = 1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_oe", m_oe, 1'b0);
    chk("abort_out", m_out, 1'b1);
    chk("abort_ready", m_ready, 1'b1);
    chk("abort_busy", m_busy, 1'b0);
    reset_n = 1'b1;
    repeat (150) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, d0);

    // CRC timeout instance
    sel = 2;
    #1;
    e0 = err_cnt;
    f0 = frames_seen;
    r0 = oe_rises;
    send(6'd0, 32'h0, 0, 48'h0);
    for (int i = 0; i < 200 && err_cnt == e0; i++) @(posedge clk);
    repeat (100) @(posedge clk);
    #1;
    chk("timeout_error_once", err_cnt, e0 + 1);
    chk("timeout_no_oe", oe_rises, r0);
    chk("timeout_no_frame", frames_seen, f0);
    chk("timeout_ready", m_ready, 1'b1);
    chk("timeout_no_done", done_cnt, d0);

    chk("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
